// File: rtl/card_shoe_if.sv
// ============================================================================
// Module   : card_shoe_if
// Brief    : Request/card bundle between the game FSM and the card shoe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface card_shoe_if;
    logic       i_request;
    logic       i_reshuffle;
    logic       i_seedStrobe;
    logic [5:0] o_card;
    logic       o_cardValid;
    logic       o_busy;
    logic       o_empty;
    logic       o_lowCards;
    logic [7:0] o_cardsRemaining;

    modport slave (
        input  i_request, i_reshuffle, i_seedStrobe,
        output o_card, o_cardValid, o_busy, o_empty, o_lowCards, o_cardsRemaining
    );

    modport master (
        output i_request, i_reshuffle, i_seedStrobe,
        input  o_card, o_cardValid, o_busy, o_empty, o_lowCards, o_cardsRemaining
    );
endinterface

`default_nettype wire

// File: rtl/card_shoe.sv
// ============================================================================
// Module   : card_shoe
// Brief    : NUM_DECKS x 52 card shoe with in-place Fisher-Yates shuffle.
//            Define CARD_SHOE_ORDERED_DECK_EN to skip shuffling (fill order).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_shoe #(
    parameter int NUM_DECKS           = 1,
    parameter int RESHUFFLE_THRESHOLD = 15
) (
    input  wire logic    i_clk,
    input  wire logic    i_reset,
    card_shoe_if.slave   bus
);

    localparam int         c_N         = 52 * NUM_DECKS;
    localparam int         c_IW        = $clog2(c_N);
    localparam logic [7:0] c_N8        = 8'(c_N);
    localparam logic [7:0] c_LAST      = 8'(c_N - 1);
    localparam logic [7:0] c_LOW       = 8'(RESHUFFLE_THRESHOLD);
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_FILL      = 3'd0,
        S_SHUF_PICK = 3'd1,
        S_SHUF_SWAP = 3'd2,
        S_RELOAD    = 3'd3,
        S_READY     = 3'd4,
        S_EMPTY     = 3'd5
    } stateT;

`ifdef CARD_SHOE_ORDERED_DECK_EN
    localparam stateT c_AFTER_FILL   = S_READY;
    localparam stateT c_AFTER_RESHUF = S_RELOAD;
`else
    localparam stateT c_AFTER_FILL   = S_SHUF_PICK;
    localparam stateT c_AFTER_RESHUF = S_SHUF_PICK;
`endif

    stateT       r_state;
    stateT       w_nextState;
    logic [5:0]  r_mem [0:c_N-1];
    logic [7:0]  r_idx;
    logic [7:0]  r_j;
    logic [7:0]  r_ptr;
    logic [7:0]  r_remaining;
    logic [3:0]  r_fillRank;
    logic [1:0]  r_fillSuit;
    logic [5:0]  r_card;
    logic        r_cardValid;
    logic [15:0] r_lfsr;
    logic [15:0] r_cycleCount;
    logic        w_deal;
    logic        w_restart;
    logic [7:0]  w_iPlus1;
    logic [7:0]  w_pick;
    logic [15:0] w_lfsrStep;
    logic [15:0] w_lfsrSeeded;

    // ------------------------------------------------------------------
    // Entropy source
    // ------------------------------------------------------------------
    assign w_lfsrStep   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
    assign w_lfsrSeeded = w_lfsrStep ^ r_cycleCount;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr       <= c_LFSR_SEED;
            r_cycleCount <= 16'd0;
        end else begin
            r_cycleCount <= r_cycleCount + 16'd1;
            if (bus.i_seedStrobe)
                r_lfsr <= (w_lfsrSeeded == 16'd0) ? c_LFSR_SEED : w_lfsrSeeded;
            else
                r_lfsr <= w_lfsrStep;
        end
    end

    // Scaling a 16-bit uniform value by (i+1) keeps j within 0..i without a divider.
    assign w_iPlus1 = r_idx + 8'd1;
    assign w_pick   = 8'(({8'd0, r_lfsr} * {16'd0, w_iPlus1}) >> 16);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_FILL;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_deal      = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_FILL: begin
                if (r_idx == c_LAST)
                    w_nextState = c_AFTER_FILL;
            end
            S_SHUF_PICK: w_nextState = S_SHUF_SWAP;
            S_SHUF_SWAP: w_nextState = (r_idx == 8'd1) ? S_READY : S_SHUF_PICK;
            S_RELOAD:    w_nextState = S_READY;
            S_READY: begin
                if (bus.i_reshuffle) begin
                    w_restart   = 1'b1;
                    w_nextState = c_AFTER_RESHUF;
                end else if (bus.i_request) begin
                    w_deal = 1'b1;
                    if (r_remaining == 8'd1)
                        w_nextState = S_EMPTY;
                end
            end
            S_EMPTY: begin
                if (bus.i_reshuffle) begin
                    w_restart   = 1'b1;
                    w_nextState = c_AFTER_RESHUF;
                end
            end
            default: w_nextState = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx       <= 8'd0;
            r_j         <= 8'd0;
            r_ptr       <= 8'd0;
            r_remaining <= c_N8;
            r_fillRank  <= 4'd1;
            r_fillSuit  <= 2'd0;
            r_card      <= 6'd0;
            r_cardValid <= 1'b0;
        end else begin
            r_cardValid <= w_deal;
            case (r_state)
                S_FILL: begin
                    // Parking the index at N-1 hands the shuffle its starting i.
                    r_idx <= (r_idx == c_LAST) ? c_LAST : r_idx + 8'd1;
                    if (r_fillRank == 4'd13) begin
                        r_fillRank <= 4'd1;
                        r_fillSuit <= r_fillSuit + 2'd1;
                    end else begin
                        r_fillRank <= r_fillRank + 4'd1;
                    end
                end
                S_SHUF_PICK: r_j   <= w_pick;
                S_SHUF_SWAP: r_idx <= r_idx - 8'd1;
                S_READY, S_EMPTY: begin
                    if (w_restart) begin
                        r_ptr       <= 8'd0;
                        r_remaining <= c_N8;
                        r_idx       <= c_LAST;
                    end else if (w_deal) begin
                        r_card      <= r_mem[r_ptr[c_IW-1:0]];
                        r_ptr       <= r_ptr + 8'd1;
                        r_remaining <= r_remaining - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Card storage carries no reset; the fill pass always rewrites every slot.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (r_state == S_FILL) begin
                r_mem[r_idx[c_IW-1:0]] <= {r_fillRank, r_fillSuit};
            end else if (r_state == S_SHUF_SWAP) begin
                r_mem[r_idx[c_IW-1:0]] <= r_mem[r_j[c_IW-1:0]];
                r_mem[r_j[c_IW-1:0]]   <= r_mem[r_idx[c_IW-1:0]];
            end
        end
    end

    assign bus.o_card           = r_card;
    assign bus.o_cardValid      = r_cardValid;
    assign bus.o_busy           = (r_state == S_FILL) || (r_state == S_SHUF_PICK) ||
                                  (r_state == S_SHUF_SWAP) || (r_state == S_RELOAD);
    assign bus.o_empty          = (r_state == S_EMPTY);
    assign bus.o_cardsRemaining = r_remaining;
    assign bus.o_lowCards       = (r_remaining < c_LOW);

endmodule

`default_nettype wire

// File: tb/tb_card_shoe.sv
// ============================================================================
// Module   : tb_card_shoe
// Brief    : Directed self-checking bench for card_shoe (shuffle or ordered build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_card_shoe;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;
    int   nAsserts = 0;
    int   nFails   = 0;

    always #5 i_clk = ~i_clk;

    card_shoe_if bus ();

    card_shoe #(
        .NUM_DECKS          (1),
        .RESHUFFLE_THRESHOLD(15)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset();
        i_reset          = 1'b1;
        bus.i_request    = 1'b0;
        bus.i_reshuffle  = 1'b0;
        bus.i_seedStrobe = 1'b0;
        step();
        i_reset = 1'b0;
    endtask

    // Counts busy cycles from the current one; strobes the seed at cycle strobeAt.
    task automatic countBusy(input int strobeAt, output int n);
        n = 0;
        while (bus.o_busy === 1'b1 && n < 1000) begin
            bus.i_seedStrobe = (n == strobeAt);
            step();
            n++;
        end
        bus.i_seedStrobe = 1'b0;
    endtask

    task automatic dealAll(output logic [5:0] seq [52]);
        for (int k = 0; k < 52; k++) begin
            bus.i_request = 1'b1;
            step();
            check("dealValid", 16'(bus.o_cardValid), 16'd1);
            seq[k] = bus.o_card;
        end
        bus.i_request = 1'b0;
    endtask

    function automatic logic isPerm(input logic [5:0] seq [52]);
        int         cnt [64];
        logic       ok;
        logic [5:0] code;
        int         want;
        ok = 1'b1;
        for (int c = 0; c < 64; c++) cnt[c] = 0;
        for (int k = 0; k < 52; k++) cnt[int'(seq[k])]++;
        for (int c = 0; c < 64; c++) begin
            code = 6'(c);
            want = (code[5:2] >= 4'd1 && code[5:2] <= 4'd13) ? 1 : 0;
            if (cnt[c] != want) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [5:0] seqA [52];
    logic [5:0] seqB [52];
    logic [5:0] lastCard;
    logic       same;
    int         n;

    initial begin
        bus.i_request    = 1'b0;
        bus.i_reshuffle  = 1'b0;
        bus.i_seedStrobe = 1'b0;

        doReset();
        check("rstBusy",      16'(bus.o_busy), 16'd1);
        check("rstEmpty",     16'(bus.o_empty), 16'd0);
        check("rstRemaining", 16'(bus.o_cardsRemaining), 16'd52);
        check("rstValid",     16'(bus.o_cardValid), 16'd0);
        check("rstCard",      16'(bus.o_card), 16'd0);
        check("rstLow",       16'(bus.o_lowCards), 16'd0);

`ifdef CARD_SHOE_ORDERED_DECK_EN
        countBusy(-1, n);
        check("fillCycles", 16'(n), 16'd52);
        for (int k = 0; k < 52; k++) begin
            bus.i_request = 1'b1;
            step();
            check("ordValid", 16'(bus.o_cardValid), 16'd1);
            check("ordCard", 16'(bus.o_card), 16'({4'(k % 13 + 1), 2'(k / 13)}));
            check("ordRemaining", 16'(bus.o_cardsRemaining), 16'(51 - k));
        end
        check("ordEmpty", 16'(bus.o_empty), 16'd1);
        step();
        check("reqWhenEmpty", 16'(bus.o_cardValid), 16'd0);
        bus.i_request   = 1'b0;
        bus.i_reshuffle = 1'b1;
        step();
        bus.i_reshuffle = 1'b0;
        check("reloadBusy", 16'(bus.o_busy), 16'd1);
        check("reloadRemaining", 16'(bus.o_cardsRemaining), 16'd52);
        check("reloadEmpty", 16'(bus.o_empty), 16'd0);
        step();
        check("reloadDone", 16'(bus.o_busy), 16'd0);
        bus.i_request = 1'b1;
        step();
        bus.i_request = 1'b0;
        check("reloadFirstCard", 16'(bus.o_card), 16'h0004);
`else
        // Two unseeded runs must match and each must be a full permutation.
        countBusy(-1, n);
        check("shuffleCycles", 16'(n), 16'd154);
        dealAll(seqA);
        check("permA", 16'(isPerm(seqA)), 16'd1);
        check("emptyAfter52", 16'(bus.o_empty), 16'd1);
        check("remainingAfter52", 16'(bus.o_cardsRemaining), 16'd0);
        check("lowAfter52", 16'(bus.o_lowCards), 16'd1);
        bus.i_request = 1'b1;
        step();
        bus.i_request = 1'b0;
        check("reqWhenEmpty", 16'(bus.o_cardValid), 16'd0);

        doReset();
        countBusy(-1, n);
        dealAll(seqB);
        same = 1'b1;
        for (int k = 0; k < 52; k++) if (seqA[k] !== seqB[k]) same = 1'b0;
        check("repeatable", 16'(same), 16'd1);

        // Seed strobe one cycle apart must change the shuffle.
        doReset();
        countBusy(10, n);
        check("seededCycles", 16'(n), 16'd154);
        dealAll(seqA);
        check("permSeed10", 16'(isPerm(seqA)), 16'd1);
        doReset();
        countBusy(11, n);
        dealAll(seqB);
        check("permSeed11", 16'(isPerm(seqB)), 16'd1);
        same = 1'b1;
        for (int k = 0; k < 52; k++) if (seqA[k] !== seqB[k]) same = 1'b0;
        check("seedDiffers", 16'(same), 16'd0);

        // Low-card threshold boundary, hold behaviour, then reshuffle beating a request.
        doReset();
        countBusy(-1, n);
        for (int k = 0; k < 37; k++) begin
            bus.i_request = 1'b1;
            step();
        end
        check("remaining15", 16'(bus.o_cardsRemaining), 16'd15);
        check("low15", 16'(bus.o_lowCards), 16'd0);
        step();
        bus.i_request = 1'b0;
        lastCard = bus.o_card;
        check("remaining14", 16'(bus.o_cardsRemaining), 16'd14);
        check("low14", 16'(bus.o_lowCards), 16'd1);
        step();
        check("idleNoValid", 16'(bus.o_cardValid), 16'd0);
        check("cardHeld", 16'(bus.o_card), 16'(lastCard));
        bus.i_request   = 1'b1;
        bus.i_reshuffle = 1'b1;
        step();
        bus.i_request   = 1'b0;
        bus.i_reshuffle = 1'b0;
        check("reshufNoCard", 16'(bus.o_cardValid), 16'd0);
        check("reshufRemaining", 16'(bus.o_cardsRemaining), 16'd52);
        countBusy(-1, n);
        check("reshufCycles", 16'(n), 16'd102);
        check("reshufLow", 16'(bus.o_lowCards), 16'd0);
        dealAll(seqA);
        check("permReshuf", 16'(isPerm(seqA)), 16'd1);

        // Reset landing in a swap cycle restarts the whole fill and shuffle.
        doReset();
        for (int k = 0; k < 53; k++) step();
        check("midSwapBusy", 16'(bus.o_busy), 16'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("reRstBusy", 16'(bus.o_busy), 16'd1);
        check("reRstRemaining", 16'(bus.o_cardsRemaining), 16'd52);
        bus.i_request = 1'b1;
        step();
        bus.i_request = 1'b0;
        check("busyReqIgnored", 16'(bus.o_cardValid), 16'd0);
        check("busyReqRemaining", 16'(bus.o_cardsRemaining), 16'd52);
        countBusy(-1, n);
        check("reRstCycles", 16'(n + 1), 16'd154);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

`default_nettype wire
